// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and helpers shared by the UART receiver, its baud timer and the
//   future transmitter.
//   - parity_e     : parity mode selection
//   - rx_state_e   : receiver FSM state encoding
//   - parity_calc  : expected parity bit of a zero-padded data word
package uart_pkg;

  // Widest data word supported; narrower words are zero-padded to this width.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Parity bit a correct transmitter sends for this data word.
  // Zero padding does not change the XOR, so any DATA_BITS <= 9 works.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_e                  mode);
    logic p;
    case (mode)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~(^data);
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
//   Receive/Received handshake between the UART receiver and its consumer.
//   - Receive   : held frame valid (receiver -> consumer)
//   - Received  : consumer acknowledge (consumer -> receiver)
//   - Dout      : held data word
//   - parityErr : parity error of the held frame
//   - frameErr  : framing error of the held frame
//   - overrun   : sticky, frames were dropped while one was held
//   - busy      : receiver FSM is not idle
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 Receive;
  logic                 Received;
  logic [DATA_BITS-1:0] Dout;
  logic                 parityErr;
  logic                 frameErr;
  logic                 overrun;
  logic                 busy;

  modport master (
    output Receive, Dout, parityErr, frameErr, overrun, busy,
    input  Received
  );

  modport slave (
    input  Receive, Dout, parityErr, frameErr, overrun, busy,
    output Received
  );
endinterface

// File: rtl/uart_baud_timer.sv
// uart_baud_timer
//   Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps.
//   - clk, Reset_n : clock, async active-low reset
//   - clr          : hold the count at 0 (count is 0 the cycle after clr)
//   - half_tick    : count == CLKS_PER_BIT/2-1 (mid-bit alignment of start bit)
//   - full_tick    : count == CLKS_PER_BIT-1 (one bit period elapsed)
module uart_baud_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: clear, wrap at the end of a bit period, otherwise increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_tick = (count_q == LAST);
  assign half_tick = (count_q == HALF);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised asynchronous serial receiver with a one-entry holding
//   register, so a new frame can arrive while the previous one is unread.
//   - clk, Reset_n : clock, async active-low reset
//   - Sin          : asynchronous serial input, idles high
//   - rx           : Receive/Received handshake, data and status flags
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 5208,
  parameter int      DATA_BITS    = 8,
  parameter parity_e PARITY       = PAR_ODD,
  parameter int      STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            Reset_n,
  input  logic            Sin,
  uart_rx_param_if.master rx
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [2:0] S_STOP   = ST_STOP;
  localparam logic [2:0] S_BREAK  = ST_BREAK;

  logic [1:0]               sync_q;
  logic                     sin_s;
  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     clr_s, done_s;
  logic                     half_tick_s, full_tick_s;
  logic [MAX_DATA_BITS-1:0] par_data_s;

  logic                     rcv_q, rcv_d;
  logic [DATA_BITS-1:0]     dout_q, dout_d;
  logic                     hperr_q, hperr_d;
  logic                     hferr_q, hferr_d;
  logic                     ovr_q, ovr_d;
  logic                     busy_q, busy_d;

  assign sin_s = sync_q[1];

  uart_baud_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .clr       (clr_s),
    .half_tick (half_tick_s),
    .full_tick (full_tick_s)
  );

  // Zero-pad the received word for the parity helper.
  always_comb begin
    par_data_s                  = '0;
    par_data_s[DATA_BITS-1:0]   = shift_q;
  end

  // Receiver FSM: framing, sampling and per-frame error accumulation.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    clr_s    = 1'b0;
    done_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Timer held at 0 so the START half tick is measured from the edge.
        clr_s = 1'b1;
        if (!sin_s) begin
          state_d  = S_START;
          bitcnt_d = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (half_tick_s) begin
          if (sin_s) begin
            state_d = S_IDLE;          // glitch, not a real start bit
          end else begin
            state_d  = S_DATA;
            clr_s    = 1'b1;           // re-phase timer to mid-bit
            bitcnt_d = '0;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (full_tick_s) begin
          shift_d = {sin_s, shift_q[DATA_BITS-1:1]};
          if (bitcnt_q == LAST_DATA) begin
            bitcnt_d = '0;
            if (PARITY == PAR_NONE) begin
              state_d = S_STOP;
            end else begin
              state_d = S_PARITY;
            end
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (full_tick_s) begin
          perr_d  = (sin_s != parity_calc(par_data_s, PARITY));
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (full_tick_s) begin
          ferr_d = ferr_q | ~sin_s;
          if (bitcnt_q == LAST_STOP) begin
            done_s   = 1'b1;
            bitcnt_d = '0;
            if (sin_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_BREAK;       // line held low: wait for it to recover
            end
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        if (sin_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register: deliver, drop-with-overrun, or clear on acknowledge.
  always_comb begin
    rcv_d   = rcv_q;
    dout_d  = dout_q;
    hperr_d = hperr_q;
    hferr_d = hferr_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != S_IDLE);
    if (done_s) begin
      if (!rcv_q || rx.Received) begin
        // Empty, or being read this very cycle: the new frame takes its place.
        rcv_d   = 1'b1;
        dout_d  = shift_q;
        hperr_d = perr_q;
        hferr_d = ferr_d;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rcv_q && rx.Received) begin
      rcv_d   = 1'b0;
      hperr_d = 1'b0;
      hferr_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      rcv_d = rcv_q;
    end
  end

  // State, synchroniser and holding registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      rcv_q    <= 1'b0;
      dout_q   <= '0;
      hperr_q  <= 1'b0;
      hferr_q  <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], Sin};
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      rcv_q    <= rcv_d;
      dout_q   <= dout_d;
      hperr_q  <= hperr_d;
      hferr_q  <= hferr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  assign rx.Receive   = rcv_q;
  assign rx.Dout      = dout_q;
  assign rx.parityErr = hperr_q;
  assign rx.frameErr  = hferr_q;
  assign rx.overrun   = ovr_q;
  assign rx.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param
//   Five receiver configurations: 8O1/8E1/8N1 at 16 clocks per bit, and
//   5E2/9O2 at 9 clocks per bit. Instance 0 is driven by directed checks;
//   the others are auto-acknowledged and compared against a queue of
//   expected frames pushed when each frame is sent.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam logic [31:0] NO_FRAME = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  sin_r = 5'b11111;
  logic        ack0 = 1'b0;
  logic        ack1 = 1'b0;
  logic        ack2 = 1'b0;
  logic        ack3 = 1'b0;
  logic        ack4 = 1'b0;
  int          cyc = 0;
  int          t_start = 0;
  int          t_rise0 = 0;
  int          rise0 = 0;
  int          fall0 = 0;
  logic        rcv0_prev = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] q4[$];
  logic [31:0] e1, e2, e3, e4;

  uart_rx_param_if #(.DATA_BITS(8)) if0 ();
  uart_rx_param_if #(.DATA_BITS(8)) if1 ();
  uart_rx_param_if #(.DATA_BITS(8)) if2 ();
  uart_rx_param_if #(.DATA_BITS(5)) if3 ();
  uart_rx_param_if #(.DATA_BITS(9)) if4 ();

  assign if0.Received = ack0;
  assign if1.Received = ack1;
  assign if2.Received = ack2;
  assign if3.Received = ack3;
  assign if4.Received = ack4;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_ODD),  .STOP_BITS(1))
    u_odd  (.clk(clk), .Reset_n(rst_n), .Sin(sin_r[0]), .rx(if0));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
    u_even (.clk(clk), .Reset_n(rst_n), .Sin(sin_r[1]), .rx(if1));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
    u_none (.clk(clk), .Reset_n(rst_n), .Sin(sin_r[2]), .rx(if2));
  uart_rx_param #(.CLKS_PER_BIT(9),  .DATA_BITS(5), .PARITY(PAR_EVEN), .STOP_BITS(2))
    u_d5   (.clk(clk), .Reset_n(rst_n), .Sin(sin_r[3]), .rx(if3));
  uart_rx_param #(.CLKS_PER_BIT(9),  .DATA_BITS(9), .PARITY(PAR_ODD),  .STOP_BITS(2))
    u_d9   (.clk(clk), .Reset_n(rst_n), .Sin(sin_r[4]), .rx(if4));

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic fe, input logic pe, input logic [8:0] d);
    return {21'd0, fe, pe, d};
  endfunction

  // Advance n clock edges and land just after the last one.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serialise one frame onto sin_r[idx], LSB first.
  task automatic send(input int idx, input int clks, input int nbits, input parity_e par,
                      input logic [8:0] data, input logic bad_par, input int nstop);
    logic pbit;
    @(posedge clk);
    #1;
    t_start = cyc;
    sin_r[idx] = 1'b0;
    hold(clks);
    for (int i = 0; i < nbits; i++) begin
      sin_r[idx] = data[i];
      hold(clks);
    end
    if (par != PAR_NONE) begin
      pbit = ^data;
      if (par == PAR_ODD) pbit = ~pbit;
      sin_r[idx] = pbit ^ bad_par;
      hold(clks);
    end
    for (int i = 0; i < nstop; i++) begin
      sin_r[idx] = 1'b1;
      hold(clks);
    end
  endtask

  task automatic send0(input logic [7:0] data, input logic bad_par);
    send(0, 16, 8, PAR_ODD, {1'b0, data}, bad_par, 1);
  endtask

  task automatic ack0_pulse();
    @(negedge clk);
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
  endtask

  // Instance 0 edge counters for delivery counting and latency.
  always @(negedge clk) begin
    if (if0.Receive && !rcv0_prev) begin
      rise0++;
      t_rise0 = cyc;
    end
    if (!if0.Receive && rcv0_prev) fall0++;
    rcv0_prev = if0.Receive;
  end

  // Scoreboard: pop and compare each delivered frame, then acknowledge it.
  always @(negedge clk) begin
    if (if1.Receive && !ack1) begin
      if (q1.size() != 0) e1 = q1.pop_front(); else e1 = NO_FRAME;
      check_eq("even_frame", pack(if1.frameErr, if1.parityErr, 9'(if1.Dout)), e1);
      ack1 = 1'b1;
    end else ack1 = 1'b0;
    if (if2.Receive && !ack2) begin
      if (q2.size() != 0) e2 = q2.pop_front(); else e2 = NO_FRAME;
      check_eq("none_frame", pack(if2.frameErr, if2.parityErr, 9'(if2.Dout)), e2);
      ack2 = 1'b1;
    end else ack2 = 1'b0;
    if (if3.Receive && !ack3) begin
      if (q3.size() != 0) e3 = q3.pop_front(); else e3 = NO_FRAME;
      check_eq("d5_frame", pack(if3.frameErr, if3.parityErr, 9'(if3.Dout)), e3);
      ack3 = 1'b1;
    end else ack3 = 1'b0;
    if (if4.Receive && !ack4) begin
      if (q4.size() != 0) e4 = q4.pop_front(); else e4 = NO_FRAME;
      check_eq("d9_frame", pack(if4.frameErr, if4.parityErr, if4.Dout), e4);
      ack4 = 1'b1;
    end else ack4 = 1'b0;
  end

  initial begin
    int snap;
    logic [8:0] d;

    // Reset state.
    hold(3);
    check_eq("rst_receive", 32'(if0.Receive), 32'd0);
    check_eq("rst_dout", 32'(if0.Dout), 32'd0);
    check_eq("rst_perr", 32'(if0.parityErr), 32'd0);
    check_eq("rst_ferr", 32'(if0.frameErr), 32'd0);
    check_eq("rst_ovr", 32'(if0.overrun), 32'd0);
    check_eq("rst_busy", 32'(if0.busy), 32'd0);
    rst_n = 1'b1;
    hold(5);

    // 8O1 frame, latency and acknowledge.
    send0(8'hA5, 1'b0);
    hold(2);
    check_eq("lat_8o1", 32'(t_rise0 - t_start), 32'd171);
    check_eq("a5_receive", 32'(if0.Receive), 32'd1);
    check_eq("a5_dout", 32'(if0.Dout), 32'hA5);
    check_eq("a5_perr", 32'(if0.parityErr), 32'd0);
    check_eq("a5_ferr", 32'(if0.frameErr), 32'd0);
    ack0_pulse();
    check_eq("a5_ack_receive", 32'(if0.Receive), 32'd0);
    check_eq("a5_dout_hold", 32'(if0.Dout), 32'hA5);

    // Wrong parity under odd / even / none.
    send0(8'h3C, 1'b1);
    hold(2);
    check_eq("odd_bad_perr", 32'(if0.parityErr), 32'd1);
    check_eq("odd_bad_dout", 32'(if0.Dout), 32'h3C);
    ack0_pulse();
    check_eq("odd_bad_perr_clr", 32'(if0.parityErr), 32'd0);
    q1.push_back(pack(1'b0, 1'b1, 9'h03C));
    send(1, 16, 8, PAR_EVEN, 9'h03C, 1'b1, 1);
    q2.push_back(pack(1'b0, 1'b0, 9'h03C));
    send(2, 16, 8, PAR_NONE, 9'h03C, 1'b1, 1);

    // Start-bit glitch shorter than half a bit.
    snap = rise0;
    sin_r[0] = 1'b0;
    hold(4);
    check_eq("glitch_busy", 32'(if0.busy), 32'd1);
    hold(1);
    sin_r[0] = 1'b1;
    hold(40);
    check_eq("glitch_idle", 32'(if0.busy), 32'd0);
    check_eq("glitch_no_rx", 32'(rise0 - snap), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    sin_r[0] = 1'b0;
    hold(40);
    check_eq("mid_busy", 32'(if0.busy), 32'd1);
    rst_n = 1'b0;
    hold(3);
    sin_r[0] = 1'b1;
    check_eq("mid_rst_busy", 32'(if0.busy), 32'd0);
    rst_n = 1'b1;
    hold(5);
    check_eq("mid_rst_no_rx", 32'(if0.Receive), 32'd0);
    snap = rise0;
    send0(8'h11, 1'b0);
    hold(2);
    check_eq("after_rst_dout", 32'(if0.Dout), 32'h11);
    check_eq("after_rst_count", 32'(rise0 - snap), 32'd1);
    ack0_pulse();

    // Line held low for 20 bit times: one frame with framing error.
    snap = rise0;
    sin_r[0] = 1'b0;
    hold(20 * 16);
    sin_r[0] = 1'b1;
    hold(40);
    check_eq("break_count", 32'(rise0 - snap), 32'd1);
    check_eq("break_dout", 32'(if0.Dout), 32'h00);
    check_eq("break_ferr", 32'(if0.frameErr), 32'd1);
    check_eq("break_perr", 32'(if0.parityErr), 32'd1);
    check_eq("break_busy", 32'(if0.busy), 32'd0);
    ack0_pulse();
    send0(8'h7E, 1'b0);
    hold(2);
    check_eq("post_break", pack(if0.frameErr, if0.parityErr, 9'(if0.Dout)), pack(1'b0, 1'b0, 9'h07E));
    ack0_pulse();

    // Overrun: two frames without acknowledge.
    send0(8'h12, 1'b0);
    send0(8'h34, 1'b0);
    hold(2);
    check_eq("ovr_receive", 32'(if0.Receive), 32'd1);
    check_eq("ovr_dout", 32'(if0.Dout), 32'h12);
    check_eq("ovr_flag", 32'(if0.overrun), 32'd1);
    ack0_pulse();
    check_eq("ovr_clr", 32'(if0.overrun), 32'd0);
    check_eq("ovr_ack_receive", 32'(if0.Receive), 32'd0);

    // Acknowledge in the same cycle a new frame is delivered.
    send0(8'h77, 1'b0);
    hold(2);
    check_eq("held_77", 32'(if0.Dout), 32'h77);
    snap = fall0;
    fork
      send0(8'h56, 1'b0);
      begin
        @(posedge clk);
        repeat (171) @(negedge clk);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
      end
    join
    hold(2);
    check_eq("same_cyc_dout", 32'(if0.Dout), 32'h56);
    check_eq("same_cyc_receive", 32'(if0.Receive), 32'd1);
    check_eq("same_cyc_ovr", 32'(if0.overrun), 32'd0);
    check_eq("same_cyc_no_drop", 32'(fall0 - snap), 32'd0);
    ack0_pulse();

    // Configuration sweep at 9 clocks per bit, two stop bits.
    for (int n = 0; n < 64; n++) begin
      d = 9'($urandom_range(0, 31));
      q3.push_back(pack(1'b0, 1'b0, d));
      send(3, 9, 5, PAR_EVEN, d, 1'b0, 2);
    end
    for (int n = 0; n < 64; n++) begin
      d = 9'($urandom_range(0, 511));
      q4.push_back(pack(1'b0, 1'b0, d));
      send(4, 9, 9, PAR_ODD, d, 1'b0, 2);
    end
    hold(20);
    check_eq("q_even_empty", 32'(q1.size()), 32'd0);
    check_eq("q_none_empty", 32'(q2.size()), 32'd0);
    check_eq("q_d5_empty", 32'(q3.size()), 32'd0);
    check_eq("q_d9_empty", 32'(q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised next-generation serial receiver: asynchronous start/stop framing, configurable data width, parity mode, stop-bit count and bit period.
- Adds an input synchroniser, false-start rejection, framing-error and overrun detection, and a one-entry holding register, so a new frame can be received while the previous one awaits acknowledgement.
- Sits between the board's serial input pin and the consumer logic, using the Receive/Received handshake.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit period (19200 baud at 100 MHz); legal range is 8 or more.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, PAR_ODD, parity mode: PAR_NONE, PAR_EVEN or PAR_ODD (type parity_e).
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Sin  input  1  serial line; asynchronous; idles high.
- Received  input  1  consumer acknowledge for the held frame.
- Receive  output  1  the held frame is valid.
- Dout  output  DATA_BITS  held data.
- parityErr  output  1  parity error flag of the held frame; always 0 when PARITY=PAR_NONE.
- frameErr  output  1  framing error flag of the held frame: at least one stop bit was sampled low.
- overrun  output  1  sticky flag: one or more frames were dropped while a frame was held.
- busy  output  1  the receiver FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - FSM goes to IDLE.
  - Synchroniser flops reset to 1.
  - Receive, parityErr, frameErr, overrun and busy are 0; Dout is 0; bit counter and timer are 0.
- Reset mid-frame: the frame is discarded and nothing is delivered.
- Synchroniser: Sin passes through 2 flops (sin_s). All FSM decisions use sin_s, which adds 2 cycles of latency.
- Timer:
  - Counts 0..CLKS_PER_BIT-1 and then wraps.
  - Produces a full tick on the wrap, i.e. every CLKS_PER_BIT cycles.
  - Produces a half tick when the count equals CLKS_PER_BIT/2-1 (integer division).
  - Is cleared in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on sin_s=0, go to START; timer starts from 0.
  - START, on the half tick:
    - sin_s=1: false start; return to IDLE; no output, no flags.
    - sin_s=0: go to DATA, restart the timer, bit count = 0.
  - DATA: on each full tick, shift sin_s in at the MSB end (LSB-first reception). After DATA_BITS samples, go to PARITY, or to STOP if PAR_NONE.
  - PARITY: on the full tick, sample the parity bit.
    - PAR_EVEN: error if XOR(data, parity bit) = 1.
    - PAR_ODD: error if XOR(data, parity bit) = 0.
  - STOP: on each full tick, sample a stop bit; any low sample sets the frame's frameErr. After STOP_BITS samples, perform the delivery step below, then:
    - final stop sample = 1: go to IDLE.
    - final stop sample = 0: go to BREAK.
  - BREAK: stay until sin_s=1, then go to IDLE. A held-low line therefore yields exactly one frame with frameErr=1.
- Delivery (the cycle after the final stop sample):
  - Receive=0: load Dout, parityErr and frameErr; Receive goes to 1.
  - Receive=1 and Received=0: the new frame is dropped, the held frame is unchanged, and overrun goes to 1.
  - Receive=1 and Received=1 in the same cycle: load the new frame; Receive stays 1; no overrun.
- Handshake:
  - Received while Receive=1 clears Receive, parityErr, frameErr and overrun on the next edge.
  - Dout holds its value after it is consumed.
  - Received while Receive=0 is ignored.
- Latency: Receive rises 2 + CLKS_PER_BIT/2 + (DATA_BITS + parity bit (1 if enabled) + STOP_BITS)*CLKS_PER_BIT + 1 cycles after the Sin falling edge (±1 for synchroniser phase).
- Width rules: the timer width is $clog2(CLKS_PER_BIT); the bit counter width is $clog2(DATA_BITS+1).
- The FSM default branch returns to IDLE; there is no X-assignment.

Decomposition:
- Package uart_pkg holds:
  - typedef parity_e: PAR_NONE, PAR_EVEN, PAR_ODD.
  - typedef rx_state_e: the six states.
  - Function parity_calc(data, mode).
- Sub-module uart_baud_timer:
  - Parameter CLKS_PER_BIT.
  - Inputs: clk, Reset_n, clr.
  - Outputs: half_tick, full_tick.
  - Shared later with the transmitter.

Test Plan (CLKS_PER_BIT=16 unless stated):
- 8O1: send 0xA5 with parity bit 1 (the XOR over data plus parity bit is 1, so odd parity is satisfied), Received held 0. Expected: Receive=1, Dout=0xA5, parityErr=0, frameErr=0 at the computed latency 2+8+160+1=171 cycles ±1. Pulse Received → Receive=0 next cycle.
- Parity: send 0x3C with a wrong parity bit under PAR_ODD, then repeat under PAR_EVEN and PAR_NONE. Expected: parityErr=1 / parityErr=1 / parityErr=0.
- Glitch: a 5-cycle low pulse on Sin (shorter than the half-bit of 8 cycles) → busy returns to 0 and Receive stays 0. Separately: Reset_n low mid-DATA, then a full frame 0x11 → Dout=0x11 and nothing spurious is delivered.
- Break: hold Sin low for 20 bit times → exactly one frame with Dout=0x00 and frameErr=1; after Sin returns high, the next frame 0x7E is received cleanly.
- Overrun: send 0x12 then 0x34 back-to-back with no acknowledge → Dout=0x12, overrun=1. Ack, then send 0x56 acked in its delivery cycle → Dout=0x56, overrun=0.
- Config sweep: DATA_BITS=5, 9 and STOP_BITS=2 with CLKS_PER_BIT=9 (odd), 64 random frames each → all data matches and no error flags.
